// File: rtl/cmd_cfg_proc_if.sv
// Command/response handshake bundle between the UART command receiver,
// the command processor and the UART transmit path.
interface cmd_cfg_proc_if;
  logic        cmd_rdy;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        send_resp;
  logic        resp_sent;

  // Upstream side: presents packets and reports transmit completion
  modport master (
    output cmd_rdy, cmd, data, resp_sent,
    input  clr_cmd_rdy, resp, send_resp
  );

  // Command processor side
  modport slave (
    input  cmd_rdy, cmd, data, resp_sent,
    output clr_cmd_rdy, resp, send_resp
  );
endinterface

// File: rtl/cmd_cfg_proc.sv
// Command processor: decodes 24-bit UART packets into flight setpoints,
// sequences motor spin-up and inertial calibration, and returns ACK/NAK.
module cmd_cfg_proc #(
  parameter bit FAST_SIM = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  cmd_cfg_proc_if.slave      bus,
  input  logic               cal_done,
  output logic               strt_cal,
  output logic               inertial_cal,
  output logic signed [15:0] d_ptch,
  output logic signed [15:0] d_roll,
  output logic signed [15:0] d_yaw,
  output logic        [8:0]  thrst,
  output logic               motors_off
);

  localparam int TW = FAST_SIM ? 9 : 25;

  localparam logic [7:0] OP_SET_PTCH  = 8'h02;
  localparam logic [7:0] OP_SET_ROLL  = 8'h03;
  localparam logic [7:0] OP_SET_YAW   = 8'h04;
  localparam logic [7:0] OP_SET_THRST = 8'h05;
  localparam logic [7:0] OP_CALIBRATE = 8'h06;
  localparam logic [7:0] OP_EMER_LAND = 8'h07;
  localparam logic [7:0] OP_MTRS_OFF  = 8'h08;

  localparam logic [7:0] ACK = 8'hA5;
  localparam logic [7:0] NAK = 8'hEE;

  typedef enum logic [1:0] {IDLE, SPINUP, CAL, WAIT_TX} state_t;

  state_t              state, nxt_state;
  logic [TW-1:0]       timer, nxt_timer;
  logic [7:0]          resp_q, nxt_resp;
  logic                send_q, nxt_send;
  logic                nxt_strt_cal, nxt_inertial_cal, nxt_motors_off;
  logic signed [15:0]  nxt_ptch, nxt_roll, nxt_yaw;
  logic        [8:0]   nxt_thrst;

  // A packet is consumed only when the processor is idle; otherwise it stays pending upstream
  assign bus.clr_cmd_rdy = (state == IDLE) && bus.cmd_rdy;
  assign bus.resp        = resp_q;
  assign bus.send_resp   = send_q;

  // Register all FSM state and outputs; reset aborts any calibration in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      timer        <= '0;
      resp_q       <= 8'h00;
      send_q       <= 1'b0;
      strt_cal     <= 1'b0;
      inertial_cal <= 1'b0;
      motors_off   <= 1'b1;
      d_ptch       <= '0;
      d_roll       <= '0;
      d_yaw        <= '0;
      thrst        <= '0;
    end else begin
      state        <= nxt_state;
      timer        <= nxt_timer;
      resp_q       <= nxt_resp;
      send_q       <= nxt_send;
      strt_cal     <= nxt_strt_cal;
      inertial_cal <= nxt_inertial_cal;
      motors_off   <= nxt_motors_off;
      d_ptch       <= nxt_ptch;
      d_roll       <= nxt_roll;
      d_yaw        <= nxt_yaw;
      thrst        <= nxt_thrst;
    end
  end

  // Decode commands and step the spin-up / calibration / transmit sequence
  always_comb begin
    nxt_state        = state;
    nxt_timer        = timer;
    nxt_resp         = resp_q;
    nxt_send         = 1'b0;
    nxt_strt_cal     = 1'b0;
    nxt_inertial_cal = inertial_cal;
    nxt_motors_off   = motors_off;
    nxt_ptch         = d_ptch;
    nxt_roll         = d_roll;
    nxt_yaw          = d_yaw;
    nxt_thrst        = thrst;

    case (state)
      IDLE: begin
        if (bus.cmd_rdy) begin
          nxt_resp  = ACK;
          nxt_send  = 1'b1;
          nxt_state = WAIT_TX;
          case (bus.cmd)
            OP_SET_PTCH:  nxt_ptch  = bus.data;
            OP_SET_ROLL:  nxt_roll  = bus.data;
            OP_SET_YAW:   nxt_yaw   = bus.data;
            OP_SET_THRST: nxt_thrst = bus.data[8:0];
            OP_CALIBRATE: begin
              nxt_resp       = resp_q;
              nxt_send       = 1'b0;
              nxt_motors_off = 1'b0;
              nxt_timer      = '0;
              nxt_state      = SPINUP;
            end
            OP_EMER_LAND: begin
              nxt_ptch  = '0;
              nxt_roll  = '0;
              nxt_yaw   = '0;
              nxt_thrst = '0;
            end
            OP_MTRS_OFF:  nxt_motors_off = 1'b1;
            default:      nxt_resp = NAK;
          endcase
        end
      end
      SPINUP: begin
        nxt_timer = timer + 1'b1;
        if (&timer) begin
          nxt_strt_cal     = 1'b1;
          nxt_inertial_cal = 1'b1;
          nxt_state        = CAL;
        end
      end
      CAL: begin
        if (cal_done) begin
          nxt_inertial_cal = 1'b0;
          nxt_resp         = ACK;
          nxt_send         = 1'b1;
          nxt_state        = WAIT_TX;
        end
      end
      WAIT_TX: begin
        if (bus.resp_sent) nxt_state = IDLE;
      end
      default: nxt_state = IDLE;
    endcase
  end

endmodule
